// File: rtl/cpu_pair_pkg.sv
// rtl/cpu_pair_pkg.sv - shared types and constants for the register-pair executor
package cpu_pair_pkg;

   typedef enum logic [1:0] {
      MOV    = 2'd0,
      INC    = 2'd1,
      DEC    = 2'd2,
      ADD_SE = 2'd3
   } pair_op_t;

   localparam int PAIR_BC = 0;
   localparam int PAIR_DE = 1;
   localparam int PAIR_HL = 2;
   localparam int PAIR_SP = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      WB   = 2'd3
   } xfer_state_t;

endpackage

// File: rtl/cpu_mcyc_counter.sv
// rtl/cpu_mcyc_counter.sv - ce-gated T-cycle / M-cycle position counter
module cpu_mcyc_counter #(
   parameter int TPM = 4
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       ce,
   input  logic       clear,
   input  logic       load,
   output logic [1:0] t_idx,
   output logic [2:0] m_idx,
   output logic       last_t
);

   localparam logic [1:0] T_LAST = 2'(TPM - 1);

   // m_idx==0 means idle; load starts at M1/T0, then T wraps into the next M
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         t_idx <= '0;
         m_idx <= '0;
      end else if (ce) begin
         if (clear) begin
            t_idx <= '0;
            m_idx <= '0;
         end else if (load) begin
            t_idx <= '0;
            m_idx <= 3'd1;
         end else if (m_idx != 3'd0) begin
            if (t_idx == T_LAST) begin
               t_idx <= '0;
               m_idx <= m_idx + 3'd1;
            end else begin
               t_idx <= t_idx + 2'd1;
            end
         end
      end
   end

   assign last_t = (m_idx != 3'd0) && (t_idx == T_LAST);

endmodule

// File: rtl/cpu_pair_xfer_unit.sv
// rtl/cpu_pair_xfer_unit.sv - sequenced executor for 16-bit register-pair MOV/INC/DEC/ADD_SE
module cpu_pair_xfer_unit
   import cpu_pair_pkg::*;
#(
   parameter int W     = 8,
   parameter int NPAIR = 4,
   parameter int TPM   = 4,
   parameter int MOV_M = 1,
   parameter int ADD_M = 2
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic                     ce,
   input  logic                     start,
   input  pair_op_t                 op,
   input  logic [$clog2(NPAIR)-1:0] src,
   input  logic [$clog2(NPAIR)-1:0] dst,
   input  logic [W-1:0]             imm,
   output logic [$clog2(NPAIR)-1:0] rd_sel,
   input  logic [2*W-1:0]           rd_data,
   output logic                     wr_en,
   output logic [$clog2(NPAIR)-1:0] wr_sel,
   output logic [2*W-1:0]           wr_data,
   output logic                     flags_we,
   output logic                     flag_h,
   output logic                     flag_c,
   output logic                     busy,
   output logic [2:0]               m_idx,
   output logic [1:0]               t_idx
);

   localparam int SW = $clog2(NPAIR);

   xfer_state_t     state_q, state_d;
   pair_op_t        op_q;
   logic [SW-1:0]   src_q, dst_q;
   logic [W-1:0]    imm_q;
   logic [W-1:0]    opnd_hi_q;
   logic [W-1:0]    lo_q;
   logic            cy_q;
   logic            h_q, c_q;
   logic [2*W-1:0]  wr_data_q;
   logic            last_t;
   logic            accept;
   logic            sample;
   logic            last_m;
   logic [W+1:0]    lo_res;
   logic [W-1:0]    hi_res;

   // Low byte: result plus carry/borrow out of bit W-1 and half-carry out of bit 3.
   // Packed as {h, c, result[W-1:0]}; for DEC the c bit is the borrow.
   function automatic logic [W+1:0] alu_lo(input pair_op_t o, input logic [W-1:0] a,
                                           input logic [W-1:0] e);
      logic [W:0] s;
      logic [4:0] hs;
      s  = {1'b0, a};
      hs = '0;
      case (o)
         INC:     s = {1'b0, a} + (W+1)'(1);
         DEC:     s = {1'b0, a} - (W+1)'(1);
         ADD_SE: begin
            s  = {1'b0, a} + {1'b0, e};
            hs = {1'b0, a[3:0]} + {1'b0, e[3:0]};
         end
         default: s = {1'b0, a};
      endcase
      return {hs[4], s};
   endfunction

   // High byte: propagate the low-byte carry/borrow; ADD_SE adds the sign extension of e
   function automatic logic [W-1:0] alu_hi(input pair_op_t o, input logic [W-1:0] a,
                                           input logic [W-1:0] e, input logic cy);
      logic [W-1:0] cyw;
      cyw = {{(W-1){1'b0}}, cy};
      case (o)
         INC:     return a + cyw;
         DEC:     return a - cyw;
         ADD_SE:  return a + {W{e[W-1]}} + cyw;
         default: return a;
      endcase
   endfunction

   assign accept = (state_q == IDLE) && ce && start;
   assign sample = (state_q == LO) && ce && (t_idx == 2'd1);
   assign last_m = (m_idx == ((op_q == ADD_SE) ? 3'(ADD_M) : 3'(MOV_M)));
   assign lo_res = alu_lo(op_q, rd_data[W-1:0], imm_q);
   assign hi_res = alu_hi(op_q, opnd_hi_q, imm_q, cy_q);

   cpu_mcyc_counter #(.TPM(TPM)) u_mcyc (
      .clk    (clk),
      .nreset (nreset),
      .ce     (ce),
      .clear  (wr_en),
      .load   (accept),
      .t_idx  (t_idx),
      .m_idx  (m_idx),
      .last_t (last_t)
   );

   // State register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state: LO samples at T1, HI takes one ce cycle, WB waits for the final T of the final M
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = LO;
         LO:      if (sample) state_d = HI;
         HI:      if (ce) state_d = WB;
         WB:      if (wr_en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand latch, low-byte capture and high-byte assembly
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         op_q      <= MOV;
         src_q     <= '0;
         dst_q     <= '0;
         imm_q     <= '0;
         opnd_hi_q <= '0;
         lo_q      <= '0;
         cy_q      <= 1'b0;
         h_q       <= 1'b0;
         c_q       <= 1'b0;
         wr_data_q <= '0;
      end else if (ce) begin
         if (accept) begin
            op_q  <= op;
            src_q <= src;
            dst_q <= dst;
            imm_q <= imm;
         end
         if (sample) begin
            opnd_hi_q <= rd_data[2*W-1:W];
            lo_q      <= lo_res[W-1:0];
            cy_q      <= lo_res[W];
            h_q       <= (op_q == ADD_SE) && lo_res[W+1];
            c_q       <= (op_q == ADD_SE) && lo_res[W];
         end
         if (state_q == HI) begin
            wr_data_q <= {hi_res, lo_q};
         end
      end
   end

   assign wr_en    = (state_q == WB) && ce && last_t && last_m;
   assign flags_we = wr_en && (op_q == ADD_SE);
   assign flag_h   = h_q;
   assign flag_c   = c_q;
   assign busy     = (state_q != IDLE);
   assign rd_sel   = src_q;
   assign wr_sel   = dst_q;
   assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_cpu_pair_xfer_unit.sv
// tb/tb_cpu_pair_xfer_unit.sv - self-checking bench for cpu_pair_xfer_unit
module tb_cpu_pair_xfer_unit;
   import cpu_pair_pkg::*;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        ce = 1'b0;
   logic        start = 1'b0;
   pair_op_t    op = MOV;
   logic [1:0]  src = '0;
   logic [1:0]  dst = '0;
   logic [7:0]  imm = '0;
   logic [1:0]  rd_sel;
   logic [15:0] rd_data;
   logic        wr_en;
   logic [1:0]  wr_sel;
   logic [15:0] wr_data;
   logic        flags_we, flag_h, flag_c, busy;
   logic [2:0]  m_idx;
   logic [1:0]  t_idx;

   logic [15:0] regs [4];

   int checks = 0;
   int errors = 0;

   typedef struct {
      pair_op_t    op;
      logic [1:0]  src;
      logic [1:0]  dst;
      logic [7:0]  imm;
      logic [15:0] init;
      logic [15:0] exp_data;
      logic        exp_fwe;
      logic        exp_h;
      logic        exp_c;
      int          exp_cyc;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  sel;
      logic [1:0]  rsel;
      logic        fwe;
      logic        h;
      logic        c;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[11];

   always #5 clk = ~clk;

   assign rd_data = regs[rd_sel];

   cpu_pair_xfer_unit dut (
      .clk      (clk),
      .nreset   (nreset),
      .ce       (ce),
      .start    (start),
      .op       (op),
      .src      (src),
      .dst      (dst),
      .imm      (imm),
      .rd_sel   (rd_sel),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .wr_data  (wr_data),
      .flags_we (flags_we),
      .flag_h   (flag_h),
      .flag_c   (flag_c),
      .busy     (busy),
      .m_idx    (m_idx),
      .t_idx    (t_idx)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " wr_en"},    32'(wr_en), 0);
      chk({tag, " flags_we"}, 32'(flags_we), 0);
      chk({tag, " busy"},     32'(busy), 0);
      chk({tag, " m_idx"},    32'(m_idx), 0);
      chk({tag, " t_idx"},    32'(t_idx), 0);
      chk({tag, " rd_sel"},   32'(rd_sel), 0);
      chk({tag, " wr_sel"},   32'(wr_sel), 0);
      chk({tag, " wr_data"},  32'(wr_data), 0);
      chk({tag, " flags"},    32'({flag_h, flag_c}), 0);
   endtask

   task automatic load_regs(input logic [1:0] s, input logic [15:0] v);
      regs[0] = 16'h1111;
      regs[1] = 16'h2222;
      regs[2] = 16'h3333;
      regs[3] = 16'h4444;
      regs[s] = v;
   endtask

   // Issue one op at the current cycle (cycle 0); cycle 1 is the first busy cycle.
   task automatic run_op(input vec_t v, input int drop_at, input int drop_len, input int restart_at);
      exp_t e;
      exp_t got;
      int   writes;
      writes = 0;
      load_regs(v.src, v.init);
      op    = v.op;
      src   = v.src;
      dst   = v.dst;
      imm   = v.imm;
      ce    = 1'b1;
      start = 1'b1;
      e.data = v.exp_data;
      e.sel  = v.dst;
      e.rsel = v.src;
      e.fwe  = v.exp_fwe;
      e.h    = v.exp_h;
      e.c    = v.exp_c;
      e.cyc  = v.exp_cyc;
      sb.push_back(e);
      tick();
      start = 1'b0;
      op    = pair_op_t'(v.op ^ 2'b01);
      src   = v.src ^ 2'b01;
      dst   = v.dst ^ 2'b10;
      imm   = ~v.imm;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         ce    = !(drop_len > 0 && cyc >= drop_at && cyc < drop_at + drop_len);
         start = (cyc == restart_at);
         #1;
         if (cyc == 1) begin
            chk("first busy", 32'(busy), 1);
            chk("first m_idx", 32'(m_idx), 1);
            chk("first t_idx", 32'(t_idx), 0);
         end
         if (wr_en) begin
            writes++;
            chk("wr_en implies busy", 32'(busy), 1);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected wr_en at cycle %0d", cyc);
            end else begin
               got = sb.pop_front();
               chk("wr_data", 32'(wr_data), 32'(got.data));
               chk("wr_sel", 32'(wr_sel), 32'(got.sel));
               chk("rd_sel", 32'(rd_sel), 32'(got.rsel));
               chk("flags_we", 32'(flags_we), 32'(got.fwe));
               chk("write cycle", cyc, got.cyc);
               if (got.fwe) chk("flag_h_c", 32'({flag_h, flag_c}), 32'({got.h, got.c}));
            end
         end
         @(posedge clk);
         #1;
      end
      ce    = 1'b1;
      start = 1'b0;
      chk("one write per start", writes, 1);
      chk("idle after op", 32'(busy), 0);
      chk("scoreboard drained", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      int stray;
      vec_t v;
      //          op      src       dst       imm    init      exp       fwe  h     c     cyc
      vecs[0]  = '{MOV,    2'd2, 2'd3, 8'hA5, 16'hC0DE, 16'hC0DE, 1'b0, 1'b0, 1'b0, 4};
      vecs[1]  = '{INC,    2'd0, 2'd0, 8'h5A, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 4};
      vecs[2]  = '{DEC,    2'd1, 2'd1, 8'h33, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4};
      vecs[3]  = '{ADD_SE, 2'd3, 2'd3, 8'h08, 16'hFFF8, 16'h0000, 1'b1, 1'b1, 1'b1, 8};
      vecs[4]  = '{ADD_SE, 2'd3, 2'd2, 8'hFF, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 8};
      vecs[5]  = '{INC,    2'd1, 2'd1, 8'h00, 16'h12FF, 16'h1300, 1'b0, 1'b0, 1'b0, 4};
      vecs[6]  = '{DEC,    2'd2, 2'd2, 8'h00, 16'h1200, 16'h11FF, 1'b0, 1'b0, 1'b0, 4};
      vecs[7]  = '{MOV,    2'd0, 2'd0, 8'h00, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b0, 4};
      vecs[8]  = '{ADD_SE, 2'd3, 2'd2, 8'h80, 16'h1234, 16'h11B4, 1'b1, 1'b0, 1'b0, 8};
      vecs[9]  = '{ADD_SE, 2'd3, 2'd3, 8'h01, 16'h00FF, 16'h0100, 1'b1, 1'b1, 1'b1, 8};
      vecs[10] = '{INC,    2'd2, 2'd1, 8'h77, 16'h00FF, 16'h0100, 1'b0, 1'b0, 1'b0, 4};

      load_regs(2'd0, 16'h1111);
      nreset = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      nreset = 1'b1;
      tick();

      // start with ce low is not taken
      op = MOV; src = 2'd2; dst = 2'd3; start = 1'b1; ce = 1'b0;
      repeat (2) tick();
      chk("start while ce low", 32'(busy), 0);
      start = 1'b0; ce = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) run_op(vecs[i], 0, 0, 0);

      // second start at cycle 2 and ce held low over cycles 3..5: single write at cycle 7
      v = vecs[0];
      v.exp_cyc = 7;
      run_op(v, 3, 3, 2);

      // reset during cycle 3 of ADD_SE abandons the op
      load_regs(2'd3, 16'hFFF8);
      op = ADD_SE; src = 2'd3; dst = 2'd2; imm = 8'h08; ce = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      nreset = 1'b0;
      #1;
      chk_all_zero("mid-op reset");
      tick();
      nreset = 1'b1;
      stray = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (wr_en || flags_we || busy) stray++;
         tick();
      end
      chk("no activity after abandoned op", stray, 0);

      run_op(vecs[0], 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
